// File: rtl/reg_file_stim_gen.sv
// Stimulus generator for a register file: writes every entry, then reads each one back and checks it against a shadow copy.
// Optional macro STIM_GEN_RAND_DATA_EN selects LFSR data instead of the (index + 0x10) pattern.
module reg_file_stim_gen #(
  parameter int         D_BIT = 8,
  parameter int         W     = 3,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [D_BIT-1:0] q,
  output logic             wr_en,
  output logic [W-1:0]     w_addr,
  output logic [D_BIT-1:0] w_data,
  output logic [W-1:0]     r_addr,
  output logic [D_BIT-1:0] gold,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt
);

  localparam int DEPTH = 1 << W;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     idx_q, idx_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       src8;
  logic [D_BIT-1:0] data_word;
  logic [D_BIT-1:0] shadow_rd;
  logic [D_BIT-1:0] shadow_q [DEPTH];

`ifdef STIM_GEN_RAND_DATA_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8 + x^6 + x^5 + x^4 + 1, advanced only while words are being written
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_WRITE)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign src8 = lfsr_q;
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign src8        = 8'(idx_q) + 8'h10;
`endif

  // LSB-aligned fit of the 8-bit source onto the data width
  for (genvar gi = 0; gi < D_BIT; gi++) begin : g_word
    if (gi < 8) begin : g_src
      assign data_word[gi] = src8[gi];
    end else begin : g_pad
      assign data_word[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) shadow_q[idx_q] <= data_word;
  end

  assign shadow_rd = shadow_q[idx_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          idx_d   = '0;
          err_d   = '0;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ: begin
        if ((q != shadow_rd) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = S_DONE;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    w_addr = '0;
    w_data = '0;
    r_addr = '0;
    gold   = '0;
    busy   = 1'b0;
    done   = 1'b0;
    pass   = 1'b0;
    case (state_q)
      S_WRITE: begin
        wr_en  = 1'b1;
        w_addr = idx_q;
        w_data = data_word;
        busy   = 1'b1;
      end
      S_READ: begin
        r_addr = idx_q;
        gold   = shadow_rd;
        busy   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_q == 8'd0);
      end
      default: ;
    endcase
  end

  assign err_cnt = err_q;

endmodule

// File: doc/reg_file_stim_gen.md
REG_FILE_STIM_GEN -- requirements
Module: reg_file_stim_gen

Interface
REQ-001 SHALL have parameter D_BIT, default 8, meaning register data width.
REQ-002 SHALL have parameter W, default 3, meaning address width (2^W entries).
REQ-003 SHALL have parameter SEED, default 8'hA5, meaning LFSR reset value (nonzero).
REQ-004 SHALL have clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  input  1  one-cycle request to run a write/read-back pass.
REQ-007 SHALL have q  input  D_BIT  DUT read data for r_addr (combinational read in DUT).
REQ-008 SHALL have wr_en  output  1  DUT write enable.
REQ-009 SHALL have w_addr  output  W  DUT write address.
REQ-010 SHALL have w_data  output  D_BIT  DUT write data.
REQ-011 SHALL have r_addr  output  W  DUT read address.
REQ-012 SHALL have gold  output  D_BIT  expected value for r_addr, from internal shadow memory.
REQ-013 SHALL have busy, done, pass  outputs  1 each  pass in progress / pass finished / finished with zero errors.
REQ-014 SHALL have err_cnt  output  8  mismatches counted in the last/current pass.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, DONE; reset state IDLE.
REQ-016 SHALL, in IDLE or DONE, on start=1 go to WRITE next cycle with index counter=0, err_cnt=0, done=0.
REQ-017 SHALL ignore start while in WRITE or READ.
REQ-018 SHALL, in WRITE, drive wr_en=1, w_addr=index, w_data=current data word, and store the word into shadow[index] on the same edge.
REQ-019 SHALL increment index each WRITE cycle; after index=2^W-1 go to READ with index=0 (exactly 2^W write cycles, no wrap within a pass).
REQ-020 SHALL, in READ, drive wr_en=0, r_addr=index, gold=shadow[index] combinationally in the same cycle.
REQ-021 SHALL, each READ cycle, compare q with gold and increment err_cnt on mismatch, saturating at 255.
REQ-022 SHALL, after index=2^W-1 in READ (exactly 2^W read cycles), go to DONE.
REQ-023 SHALL, in DONE, hold done=1, pass=(err_cnt==0), err_cnt stable until next start.
REQ-024 SHALL drive busy=1 exactly in WRITE and READ; wr_en=0 outside WRITE; done=0 and pass=0 outside DONE.
REQ-025 SHALL keep w_addr, w_data, r_addr, gold at 0 outside their active state.
REQ-026 SHALL advance the data source only on WRITE cycles; it is not re-seeded by start.
REQ-027 SHALL truncate or zero-extend the 8-bit data source to D_BIT (LSB-aligned).
REQ-028 SHALL make a full pass take 2*2^W cycles from WRITE entry to DONE entry (16 for W=3).

Reset
REQ-029 SHALL, on rst=0 at any time including mid-pass, immediately force IDLE, all outputs 0, index=0, err_cnt=0, data source to its initial value.
REQ-030 SHALL not require shadow memory clear on reset (contents are rewritten before every read).
REQ-031 SHALL leave IDLE only on start sampled after rst has returned high.

Configuration
REQ-032 SHALL honour macro STIM_GEN_RAND_DATA_EN.
REQ-033 SHALL, with STIM_GEN_RAND_DATA_EN defined, source data from an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset to SEED, one shift per WRITE cycle.
REQ-034 SHALL, without STIM_GEN_RAND_DATA_EN, source data as (index zero-extended to 8 bits) + 8'h10.

Verification
REQ-035 Reset then idle: rst low 3 cycles, release -> IDLE, busy=done=pass=wr_en=0, err_cnt=0.
REQ-036 Macro off, start, ideal register file on q: writes addr0..7 with 0x10..0x17, reads gold 0x10..0x17, DONE after 16 cycles, pass=1, err_cnt=0.
REQ-037 Macro off, DUT model with bit 0 of entry 5 stuck at 0: read of addr5 gold=0x15, q=0x14 -> err_cnt=1, pass=0.
REQ-038 Start pulsed mid-WRITE and mid-READ -> no restart, pass still completes in 16 cycles; start in DONE -> new pass, err_cnt cleared.
REQ-039 rst asserted on 4th READ cycle -> IDLE same cycle, all outputs 0; subsequent start runs full clean pass.
REQ-040 Macro on, SEED=8'hA5: first written word 0xA5, second is one LFSR shift of 0xA5, gold sequence equals write sequence, pass=1.
